// File: rtl/npu_pkg.sv
// Shared definitions for the NPU result collector: default widths/limits
// and the collector state enumeration.
package npu_pkg;

   localparam int unsigned NPU_DATA_W  = 16;
   localparam int unsigned NPU_DEPTH   = 64;
   localparam int unsigned NPU_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      COL_IDLE    = 2'd0,
      COL_CAPTURE = 2'd1,
      COL_DONE    = 2'd2
   } col_state_e;

endpackage

// File: rtl/result_ram.sv
// Capture buffer: simple dual-port RAM, synchronous write, registered read.
// Storage is not reset; only the read output register is.
module result_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: storage has no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port: old content on same-address read/write, holds when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/npu_result_collector.sv
// NPU result collector: captures a programmed number of output words into
// a buffer, keeps a running checksum, and flags overflow and idle timeout.
module npu_result_collector
   import npu_pkg::*;
#(
   parameter int unsigned DATA_W  = NPU_DATA_W,
   parameter int unsigned DEPTH   = NPU_DEPTH,
   parameter int unsigned TIMEOUT = NPU_TIMEOUT,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic [AW:0]       expected_cnt,
   input  logic [DATA_W-1:0] output_data,
   input  logic              output_vld,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_vld,
   output logic [AW:0]       word_cnt,
   output logic [DATA_W-1:0] checksum,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              timeout
);

   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   col_state_e        state_q, state_d;
   logic [AW:0]       exp_q;
   logic [AW:0]       word_cnt_q;
   logic [AW:0]       word_cnt_inc;
   logic [DATA_W-1:0] checksum_q;
   logic [IW-1:0]     idle_q;
   logic              ovf_q;
   logic              to_q;
   logic              rd_vld_q;
   logic              capturing;
   logic              buf_full;
   logic              wr_en;
   logic              drop;
   logic              idle_hit;

   // Word acceptance and timeout decode; arm-cycle words are ignored.
   always_comb begin
      capturing    = (state_q == COL_CAPTURE) && !arm;
      buf_full     = word_cnt_q[AW];
      word_cnt_inc = word_cnt_q + 1'b1;
      wr_en        = capturing && output_vld && !buf_full;
      drop         = capturing && output_vld && buf_full;
      idle_hit     = capturing && !output_vld && (idle_q == IW'(TIMEOUT - 1));
   end

   // Next-state logic; arm restarts from any state.
   always_comb begin
      state_d = state_q;
      if (arm) begin
         state_d = (expected_cnt == '0) ? COL_DONE : COL_CAPTURE;
      end else begin
         case (state_q)
            COL_IDLE: state_d = COL_IDLE;
            COL_CAPTURE: begin
               if (wr_en && (word_cnt_inc == exp_q)) begin
                  state_d = COL_DONE;
               end else if (idle_hit) begin
                  state_d = COL_DONE;
               end
            end
            COL_DONE: state_d = COL_DONE;
            default:  state_d = COL_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture counters, checksum and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q      <= '0;
         word_cnt_q <= '0;
         checksum_q <= '0;
         idle_q     <= '0;
         ovf_q      <= 1'b0;
         to_q       <= 1'b0;
      end else if (arm) begin
         exp_q      <= expected_cnt;
         word_cnt_q <= '0;
         checksum_q <= '0;
         idle_q     <= '0;
         ovf_q      <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         if (wr_en) begin
            word_cnt_q <= word_cnt_inc;
            checksum_q <= checksum_q + output_data;
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
         if (capturing) begin
            idle_q <= output_vld ? '0 : idle_q + 1'b1;
         end
         if (idle_hit) begin
            to_q <= 1'b1;
         end
      end
   end

   // Read-valid tracks the registered read port one cycle behind rd_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_en;
      end
   end

   result_ram #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .wr_addr(word_cnt_q[AW-1:0]),
      .wr_data(output_data),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
   );

   assign rd_vld   = rd_vld_q;
   assign word_cnt = word_cnt_q;
   assign checksum = checksum_q;
   assign busy     = (state_q == COL_CAPTURE);
   assign done     = (state_q == COL_DONE);
   assign overflow = ovf_q;
   assign timeout  = to_q;

endmodule

// File: tb/tb_npu_result_collector.sv
// Testbench for npu_result_collector: directed scenarios plus randomized
// traffic, checked each cycle against a list-based behavioural model.
module tb_npu_result_collector;

   localparam int DW    = 16;
   localparam int DEPTH = 64;
   localparam int TMO   = 48;
   localparam int AW    = 6;

   localparam int M_IDLE = 0;
   localparam int M_CAP  = 1;
   localparam int M_DONE = 2;

   logic          clk = 1'b0;
   logic          rst, arm, output_vld, rd_en;
   logic [AW:0]   expected_cnt;
   logic [DW-1:0] output_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_vld;
   logic [AW:0]   word_cnt;
   logic [DW-1:0] checksum;
   logic          busy, done, overflow, timeout;

   always #5 clk = ~clk;

   npu_result_collector #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .TIMEOUT(TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .arm         (arm),
      .expected_cnt(expected_cnt),
      .output_data (output_data),
      .output_vld  (output_vld),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_vld      (rd_vld),
      .word_cnt    (word_cnt),
      .checksum    (checksum),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .timeout     (timeout)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model: a capture is the list of words stored so far.
   int            m_mode;
   logic [DW-1:0] m_q[$];
   int            m_exp;
   int            m_idle;
   bit            m_ovf, m_to, m_rdv;
   logic [DW-1:0] m_rdd;
   bit            m_rdd_known;
   logic [DW-1:0] m_mem[DEPTH];
   bit            m_known[DEPTH];
   bit            started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] m_sum();
      logic [DW-1:0] s;
      s = '0;
      foreach (m_q[i]) s = s + m_q[i];
      return s;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_mode = M_IDLE;
         m_q.delete();
         m_exp = 0; m_idle = 0;
         m_ovf = 0; m_to = 0; m_rdv = 0;
         m_rdd = '0; m_rdd_known = 1;
         foreach (m_known[i]) m_known[i] = 0;
      end else begin
         if (rd_en) begin
            m_rdv       = 1;
            m_rdd       = m_mem[rd_addr];
            m_rdd_known = m_known[rd_addr];
         end else begin
            m_rdv = 0;
         end
         if (arm) begin
            m_q.delete();
            m_idle = 0; m_ovf = 0; m_to = 0;
            m_exp  = int'(expected_cnt);
            m_mode = (m_exp == 0) ? M_DONE : M_CAP;
         end else if (m_mode == M_CAP) begin
            if (output_vld) begin
               m_idle = 0;
               if (m_q.size() < DEPTH) begin
                  m_mem[m_q.size()]   = output_data;
                  m_known[m_q.size()] = 1;
                  m_q.push_back(output_data);
                  if (m_q.size() == m_exp) m_mode = M_DONE;
               end else begin
                  m_ovf = 1;
               end
            end else begin
               m_idle++;
               if (m_idle == TMO) begin
                  m_to   = 1;
                  m_mode = M_DONE;
               end
            end
         end
      end
   endtask

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (started) begin
         check("word_cnt", word_cnt, m_q.size());
         check("checksum", checksum, m_sum());
         check("busy", busy, m_mode == M_CAP);
         check("done", done, m_mode == M_DONE);
         check("overflow", overflow, m_ovf);
         check("timeout", timeout, m_to);
         check("rd_vld", rd_vld, m_rdv);
         if (m_rdd_known) check("rd_data", rd_data, m_rdd);
      end
   end

   task automatic step(input bit r, input bit a, input int e, input bit v,
                       input logic [DW-1:0] d, input bit re, input int ra);
      @(negedge clk);
      rst          = r;
      arm          = a;
      expected_cnt = (AW+1)'(e);
      output_vld   = v;
      output_data  = d;
      rd_en        = re;
      rd_addr      = AW'(ra);
      @(posedge clk);
      model_step();
      started = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, DW'($urandom), 0, 0);
   endtask

   task automatic word(input logic [DW-1:0] d);
      step(0, 0, 0, 1, d, 0, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rd_exp [4];
      int vld_pct, arm_div;
      bit r, a, v, re;
      int e;
      rd_exp[0] = 16'h0001; rd_exp[1] = 16'h0002;
      rd_exp[2] = 16'h0003; rd_exp[3] = 16'hFFFF;
      rst = 1; arm = 0; expected_cnt = '0; output_vld = 0;
      output_data = '0; rd_en = 0; rd_addr = '0;

      // Reset with traffic present.
      step(1, 1, 4, 1, 16'h1234, 1, 0);
      step(1, 0, 0, 1, 16'h1234, 0, 0);
      #1;
      check("rst_word_cnt", word_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_rd_data", rd_data, 0);

      // Four-word capture with wrapping checksum.
      step(0, 1, 4, 0, 0, 0, 0);
      word(16'h0001); word(16'h0002); word(16'h0003); word(16'hFFFF);
      #1;
      check("cap4_done", done, 1);
      check("cap4_word_cnt", word_cnt, 4);
      check("cap4_checksum", checksum, 16'h0005);
      check("cap4_model_sum", m_sum(), 16'h0005);
      check("cap4_overflow", overflow, 0);
      check("cap4_timeout", timeout, 0);

      // Back-to-back reads of the captured words.
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 1, i);
         #1;
         check("rd_vld_seq", rd_vld, 1);
         check("rd_data_seq", rd_data, rd_exp[i]);
      end
      idle(1);
      #1;
      check("rd_hold_vld", rd_vld, 0);
      check("rd_hold_data", rd_data, 16'hFFFF);

      // Overflow: expect more words than the buffer holds.
      step(0, 1, 65, 0, 0, 0, 0);
      for (int i = 0; i < 66; i++) word(DW'($urandom));
      #1;
      check("ovf_word_cnt", word_cnt, 64);
      check("ovf_flag", overflow, 1);
      check("ovf_busy", busy, 1);
      idle(TMO - 1);
      #1;
      check("ovf_busy_pre_to", busy, 1);
      idle(1);
      #1;
      check("ovf_timeout", timeout, 1);
      check("ovf_done", done, 1);

      // Timeout after three words.
      step(0, 1, 8, 0, 0, 0, 0);
      word(16'h0010); word(16'h0020); word(16'h0030);
      idle(TMO);
      #1;
      check("to_timeout", timeout, 1);
      check("to_done", done, 1);
      check("to_word_cnt", word_cnt, 3);

      // One idle cycle short of timeout, then a word.
      step(0, 1, 8, 0, 0, 0, 0);
      word(16'h0010); word(16'h0020); word(16'h0030);
      idle(TMO - 1);
      word(16'h0040);
      #1;
      check("noto_timeout", timeout, 0);
      check("noto_busy", busy, 1);
      check("noto_word_cnt", word_cnt, 4);

      // Re-arm mid-capture with output_vld held high.
      step(0, 1, 8, 0, 0, 0, 0);
      word(16'h1111); word(16'h2222);
      step(0, 1, 1, 1, 16'hDEAD, 0, 0);
      word(16'hBEEF);
      #1;
      check("rearm_done", done, 1);
      check("rearm_word_cnt", word_cnt, 1);
      check("rearm_checksum", checksum, 16'hBEEF);
      step(0, 0, 0, 0, 0, 1, 0);
      #1;
      check("rearm_rd_data", rd_data, 16'hBEEF);

      // Reset mid-capture with output_vld high, then words in IDLE.
      step(0, 1, 8, 0, 0, 0, 0);
      word(16'h0101); word(16'h0202);
      step(1, 0, 0, 1, 16'h0303, 0, 0);
      #1;
      check("rstmid_word_cnt", word_cnt, 0);
      check("rstmid_checksum", checksum, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_rd_vld", rd_vld, 0);
      word(16'h0404);
      #1;
      check("idle_vld_word_cnt", word_cnt, 0);
      check("idle_vld_busy", busy, 0);

      // Randomized traffic in segments of varying density.
      for (int seg = 0; seg < 8; seg++) begin
         vld_pct = (seg % 4 == 3) ? 2 : 20 + 20 * (seg % 4);
         arm_div = (seg % 2 == 0) ? 40 : 300;
         for (int c = 0; c < 500; c++) begin
            r  = ($urandom % 400) == 0;
            a  = ($urandom % arm_div) == 0;
            e  = (($urandom % 8) == 0) ? int'($urandom % 128) : int'($urandom % 20);
            v  = ($urandom % 100) < vld_pct;
            re = ($urandom % 2) == 0;
            step(r, a, e, v, DW'($urandom), re, int'($urandom % DEPTH));
         end
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
